// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared entry types for the reservation-station tag queue
package rv32i_types;

    localparam int RS_TAG_W = 5;
    localparam int RS_XLEN  = 32;

    // One source operand: either a captured value (rdy=1) or the producer tag it waits on.
    typedef struct packed {
        logic                rdy;
        logic [RS_TAG_W-1:0] tag;
        logic [RS_XLEN-1:0]  data;
    } rs_src_t;

    // Per-entry bookkeeping; the opaque payload lives in its own vector array in the top.
    typedef struct packed {
        logic                valid;
        logic [RS_TAG_W-1:0] rd_tag;
        rs_src_t             rs1;
        rs_src_t             rs2;
    } rs_entry_t;

endpackage

// File: rtl/rs_tag_queue_age_select.sv
// rtl/rs_tag_queue_age_select.sv - age matrix picking the oldest ready entry
module rs_age_select #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant,
    output logic             any_ready
);

    // older[i][j] set means entry i was written before entry j.
    logic [DEPTH-1:0] older [DEPTH];

    // A new entry is younger than everything present; a freed entry claims no seniority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (i == j)        older[i][j] <= 1'b0;
                    else if (alloc[i]) older[i][j] <= 1'b0;
                    else if (alloc[j]) older[i][j] <= 1'b1;
                    else if (free[i])  older[i][j] <= 1'b0;
                end
            end
        end
    end

    // Grant the ready entry that no other ready entry is older than.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && older[j][i]) grant[i] = 1'b0;
            end
        end
    end

    assign any_ready = |ready;

endmodule

// File: rtl/rs_tag_queue.sv
// rtl/rs_tag_queue.sv - reservation station with CDB tag wakeup and oldest-ready issue
module rs_tag_queue
    import rv32i_types::*;
#(
    parameter int DEPTH         = 8,
    parameter int NUM_CDB       = 2,
    parameter int ROB_IDX_WIDTH = RS_TAG_W,
    parameter int XLEN          = RS_XLEN,
    parameter int PAYLOAD_W     = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             dispatch_valid,
    output logic                             dispatch_ready,
    input  logic [PAYLOAD_W-1:0]             dispatch_payload,
    input  logic [ROB_IDX_WIDTH-1:0]         dispatch_rd_tag,
    input  logic                             dispatch_rs1_rdy,
    input  logic [ROB_IDX_WIDTH-1:0]         dispatch_rs1_tag,
    input  logic [XLEN-1:0]                  dispatch_rs1_data,
    input  logic                             dispatch_rs2_rdy,
    input  logic [ROB_IDX_WIDTH-1:0]         dispatch_rs2_tag,
    input  logic [XLEN-1:0]                  dispatch_rs2_data,
    input  logic [NUM_CDB-1:0]               cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_WIDTH-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]          cdb_data,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [PAYLOAD_W-1:0]             issue_payload,
    output logic [ROB_IDX_WIDTH-1:0]         issue_rd_tag,
    output logic [XLEN-1:0]                  issue_rs1_data,
    output logic [XLEN-1:0]                  issue_rs2_data,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    rs_entry_t            entries  [DEPTH];
    logic [PAYLOAD_W-1:0] payloads [DEPTH];

    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] grant;
    logic             dispatch_fire;
    logic             issue_fire;
    rs_src_t          new_rs1;
    rs_src_t          new_rs2;

    // A waiting source captures the lowest-numbered matching broadcast; ready sources are frozen.
    function automatic rs_src_t snoop(input rs_src_t s,
                                      input logic [NUM_CDB-1:0] v,
                                      input logic [NUM_CDB*ROB_IDX_WIDTH-1:0] t,
                                      input logic [NUM_CDB*XLEN-1:0] d);
        rs_src_t r;
        r = s;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (!s.rdy && v[p] && t[p*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == s.tag) begin
                r.rdy  = 1'b1;
                r.data = d[p*XLEN +: XLEN];
            end
        end
        return r;
    endfunction

    // Ready depends on registered occupancy only, so an issue never frees a slot the same cycle.
    assign dispatch_ready = (occupancy != OCC_W'(DEPTH));
    assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
    assign issue_fire     = issue_valid && issue_ready && !flush;

    assign new_rs1 = '{rdy: dispatch_rs1_rdy, tag: dispatch_rs1_tag, data: dispatch_rs1_data};
    assign new_rs2 = '{rdy: dispatch_rs2_rdy, tag: dispatch_rs2_tag, data: dispatch_rs2_data};

    // Lowest-index free slot and the per-entry fully-ready vector.
    always_comb begin
        alloc_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entries[i].valid) alloc_oh = DEPTH'(1) << i;
        end
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = entries[i].valid && entries[i].rs1.rdy && entries[i].rs2.rdy;
        end
    end

    rs_age_select #(.DEPTH(DEPTH)) u_age (
        .clk       (clk),
        .rst       (rst),
        .alloc     (alloc_oh & {DEPTH{dispatch_fire}}),
        .free      (grant & {DEPTH{issue_fire}}),
        .ready     (ready_vec),
        .grant     (grant),
        .any_ready (issue_valid)
    );

    // Entry array update: wakeup, issue invalidation and dispatch write share one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i]  <= '0;
                payloads[i] <= '0;
            end
            occupancy <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
            occupancy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].valid) begin
                    entries[i].rs1 <= snoop(entries[i].rs1, cdb_valid, cdb_tag, cdb_data);
                    entries[i].rs2 <= snoop(entries[i].rs2, cdb_valid, cdb_tag, cdb_data);
                end
                if (issue_fire && grant[i]) entries[i].valid <= 1'b0;
                if (dispatch_fire && alloc_oh[i]) begin
                    entries[i].valid  <= 1'b1;
                    entries[i].rd_tag <= dispatch_rd_tag;
                    entries[i].rs1    <= snoop(new_rs1, cdb_valid, cdb_tag, cdb_data);
                    entries[i].rs2    <= snoop(new_rs2, cdb_valid, cdb_tag, cdb_data);
                    payloads[i]       <= dispatch_payload;
                end
            end
            occupancy <= occupancy + OCC_W'(dispatch_fire) - OCC_W'(issue_fire);
        end
    end

    // Drive issue fields from the one-hot grant; all zero when nothing is ready.
    always_comb begin
        issue_payload  = '0;
        issue_rd_tag   = '0;
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_payload  = payloads[i];
                issue_rd_tag   = entries[i].rd_tag;
                issue_rs1_data = entries[i].rs1.data;
                issue_rs2_data = entries[i].rs2.data;
            end
        end
    end

endmodule
